// File: rtl/mult_state_sequencer_pkg.sv
// Shared definitions for the 4x4 shift-add multiplier controller.
// The state codes are fixed because the control-signal decoder decodes them directly.
package mult_ctrl_pkg;

    // Multiplier operand width, which is also the number of add/shift iterations.
    localparam int N_BITS = 4;
    // Iteration counter width; must equal $clog2(N_BITS).
    localparam int CNT_W  = 2;

    // Present-state codes seen by the decoder:
    //   S_IDLE -> ready
    //   S_CLR  -> sig_rst
    //   S_LD   -> ld1
    //   S_ADD  -> ld2, s0, s1
    //   S_SHF  -> ld2, s0
    //   S_FIN  -> ld2, s1
    //   S_OUT  -> ld2
    // S_ILL is never entered on purpose. It is named so the FSM can recover from it.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_CLR  = 3'b001,
        S_LD   = 3'b010,
        S_ADD  = 3'b011,
        S_SHF  = 3'b100,
        S_FIN  = 3'b101,
        S_OUT  = 3'b110,
        S_ILL  = 3'b111
    } state_e;

endpackage

// File: rtl/mult_state_sequencer_if.sv
// Handshake between the multiplier top level/datapath and the state sequencer.
// master: the side that requests a multiply and supplies the multiplier LSB.
// slave:  the sequencer, which returns the present state and its status.
interface mult_state_sequencer_if #(
    parameter int CNT_W = mult_ctrl_pkg::CNT_W
);
    logic             start;
    logic             q0;
    logic [2:0]       ps;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             last;

    modport master (output start, q0, input ps, cnt, busy, last);
    modport slave  (input start, q0, output ps, cnt, busy, last);
endinterface

// File: rtl/mult_state_sequencer_iter_counter.sv
// Iteration counter with synchronous clear, count enable, and a terminal flag
// that goes high on the final iteration (cnt == N_BITS-1).
module iter_counter #(
    parameter int N_BITS = mult_ctrl_pkg::N_BITS,
    parameter int CNT_W  = mult_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    // The count register. Clear takes priority over enable.
    always_ff @(posedge clk) begin
        // NOTE: reset here is synchronous. rst is just another input sampled on the
        //       clock edge, so it is not in the sensitivity list.
        // NOTE: sequential state uses <= so that every flop samples its pre-edge value.
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/mult_state_sequencer.sv
// Present-state generator for the shift-add multiplier controller.
// It holds the 3-bit state register, the next-state logic and the iteration counter.
// start and q0 only affect the next state, so the outputs have no combinational path
// from them.
module mult_state_sequencer
    import mult_ctrl_pkg::*;
#(
    parameter int N_BITS = mult_ctrl_pkg::N_BITS,
    parameter int CNT_W  = mult_ctrl_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_state_sequencer_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_term;

    iter_counter #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt_q),
        .term (cnt_term)
    );

    // Present-state register. rst discards any multiply that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and counter control. start is sampled only in S_IDLE.
    // q0 is sampled only in S_LD and in a non-final S_SHF.
    always_comb begin
        // NOTE: give every output a default before the case so that no path
        //       leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_LD;
                cnt_clr = 1'b1;
            end
            S_LD: begin
                state_d = bus.q0 ? S_ADD : S_SHF;
            end
            S_ADD: begin
                state_d = S_SHF;
            end
            S_SHF: begin
                if (cnt_term) begin
                    state_d = S_FIN;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = bus.q0 ? S_ADD : S_SHF;
                end
            end
            S_FIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                // The counter holds N_BITS-1 through S_OUT. It is cleared on the edge
                // that returns to S_IDLE, so idle always shows cnt == 0.
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
            S_ILL: begin
                // Recovery from the unused code in a single cycle.
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    assign bus.ps   = state_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.last = (state_q == S_SHF) && cnt_term;

endmodule

// File: tb/tb_mult_state_sequencer.sv
// Directed testbench for mult_state_sequencer.
// Each step drives start, rst and q0 on the falling edge and queues the expected
// {ps, cnt, busy, last} for the following rising edge. It then compares the DUT
// output against that queue entry 1 ns after the edge.
module tb_mult_state_sequencer;
    import mult_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] ps;
        logic [1:0] cnt;
        logic       busy;
        logic       last;
    } obs_t;

    logic clk;
    logic rst;

    mult_state_sequencer_if #(.CNT_W(2)) bus ();

    mult_state_sequencer #(
        .N_BITS (4),
        .CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    obs_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         step_no = 0;
    logic [3:0] mult = 4'b0000;
    logic [2:0] cur_ps = 3'b000;
    logic [1:0] cur_cnt = 2'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value of q0 that the datapath would present in the state the bench expects the
    // DUT to be in. In states where q0 is not sampled, the value is random.
    function automatic logic pick_q0();
        int idx;
        if (cur_ps == 3'b010) begin
            return mult[0];
        end else if (cur_ps == 3'b100 && cur_cnt != 2'd3) begin
            idx = int'(cur_cnt) + 1;
            return mult[idx];
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cycle(input string tag, input logic r, input logic st,
                         input logic [2:0] eps, input logic [1:0] ecnt);
        obs_t e;
        obs_t o;
        @(negedge clk);
        rst       = r;
        bus.start = st;
        bus.q0    = pick_q0();
        e.ps   = eps;
        e.cnt  = ecnt;
        e.busy = (eps != 3'b000);
        e.last = (eps == 3'b100) && (ecnt == 2'd3);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        o = {bus.ps, bus.cnt, bus.busy, bus.last};
        e = exp_q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s step=%0d observed ps=%b cnt=%0d busy=%b last=%b expected ps=%b cnt=%0d busy=%b last=%b",
                   tag, step_no, o.ps, o.cnt, o.busy, o.last, e.ps, e.cnt, e.busy, e.last);
        end
        cur_ps  = eps;
        cur_cnt = ecnt;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.q0    = 1'b0;

        // Power-on reset, then release with start low.
        cycle("por",      1, 0, 3'b000, 2'd0);
        cycle("por",      1, 0, 3'b000, 2'd0);
        cycle("por_rel",  0, 0, 3'b000, 2'd0);

        // Run to S_FIN, then hold rst for two cycles with start high.
        mult = 4'b0000;
        cycle("rst_fin",  0, 1, 3'b001, 2'd0);
        cycle("rst_fin",  0, 0, 3'b010, 2'd0);
        cycle("rst_fin",  0, 0, 3'b100, 2'd0);
        cycle("rst_fin",  0, 0, 3'b100, 2'd1);
        cycle("rst_fin",  0, 0, 3'b100, 2'd2);
        cycle("rst_fin",  0, 0, 3'b100, 2'd3);
        cycle("rst_fin",  0, 0, 3'b101, 2'd3);
        cycle("rst_hold", 1, 1, 3'b000, 2'd0);
        cycle("rst_hold", 1, 1, 3'b000, 2'd0);
        cycle("rst_rel",  0, 0, 3'b000, 2'd0);

        // Multiplier 0000: shifts only, and last is high only on the fourth S_SHF.
        mult = 4'b0000;
        cycle("m0000",    0, 1, 3'b001, 2'd0);
        cycle("m0000",    0, 0, 3'b010, 2'd0);
        cycle("m0000",    0, 0, 3'b100, 2'd0);
        cycle("m0000",    0, 0, 3'b100, 2'd1);
        cycle("m0000",    0, 0, 3'b100, 2'd2);
        cycle("m0000",    0, 0, 3'b100, 2'd3);
        cycle("m0000",    0, 0, 3'b101, 2'd3);
        cycle("m0000",    0, 0, 3'b110, 2'd3);
        cycle("m0000",    0, 0, 3'b000, 2'd0);
        cycle("idle",     0, 0, 3'b000, 2'd0);

        // Multiplier 1111: ADD and SHF alternate. start pulses in ADD/SHF are ignored.
        mult = 4'b1111;
        cycle("m1111",    0, 1, 3'b001, 2'd0);
        cycle("m1111",    0, 0, 3'b010, 2'd0);
        cycle("m1111",    0, 0, 3'b011, 2'd0);
        cycle("m1111_st", 0, 1, 3'b100, 2'd0);
        cycle("m1111",    0, 0, 3'b011, 2'd1);
        cycle("m1111_st", 0, 1, 3'b100, 2'd1);
        cycle("m1111",    0, 0, 3'b011, 2'd2);
        cycle("m1111",    0, 0, 3'b100, 2'd2);
        cycle("m1111_st", 0, 1, 3'b011, 2'd3);
        cycle("m1111_st", 0, 1, 3'b100, 2'd3);
        cycle("m1111",    0, 0, 3'b101, 2'd3);
        cycle("m1111",    0, 0, 3'b110, 2'd3);
        cycle("m1111",    0, 0, 3'b000, 2'd0);
        cycle("idle",     0, 0, 3'b000, 2'd0);

        // Multiplier 1010 with start held high. S_IDLE lasts one cycle before the restart.
        mult = 4'b1010;
        cycle("m1010",    0, 1, 3'b001, 2'd0);
        cycle("m1010",    0, 1, 3'b010, 2'd0);
        cycle("m1010",    0, 1, 3'b100, 2'd0);
        cycle("m1010",    0, 1, 3'b011, 2'd1);
        cycle("m1010",    0, 1, 3'b100, 2'd1);
        cycle("m1010",    0, 1, 3'b100, 2'd2);
        cycle("m1010",    0, 1, 3'b011, 2'd3);
        cycle("m1010",    0, 1, 3'b100, 2'd3);
        cycle("m1010",    0, 1, 3'b101, 2'd3);
        cycle("m1010",    0, 1, 3'b110, 2'd3);
        cycle("held_idl", 0, 1, 3'b000, 2'd0);
        cycle("held_clr", 0, 1, 3'b001, 2'd0);

        // The restarted job runs with multiplier 0000 until the illegal code is forced.
        mult = 4'b0000;
        cycle("restart",  0, 0, 3'b010, 2'd0);
        cycle("restart",  0, 0, 3'b100, 2'd0);
        cycle("restart",  0, 0, 3'b100, 2'd1);
        cycle("restart",  0, 0, 3'b100, 2'd2);

        // Force the unused state code for one edge. It must recover to idle with cnt 0.
        @(negedge clk);
        force dut.state_q = S_ILL;
        #1;
        release dut.state_q;
        #1;
        checks++;
        assert (bus.ps === 3'b111) else begin
            errors++;
            $error("FAIL forced_ill observed ps=%b expected ps=111", bus.ps);
        end
        cur_ps = 3'b111;
        cycle("ill_rec",  0, 0, 3'b000, 2'd0);
        cycle("idle",     0, 0, 3'b000, 2'd0);

        // Assert rst in S_ADD of iteration 2 (multiplier 1111).
        mult = 4'b1111;
        cycle("rst_add",  0, 1, 3'b001, 2'd0);
        cycle("rst_add",  0, 0, 3'b010, 2'd0);
        cycle("rst_add",  0, 0, 3'b011, 2'd0);
        cycle("rst_add",  0, 0, 3'b100, 2'd0);
        cycle("rst_add",  0, 0, 3'b011, 2'd1);
        cycle("rst_add",  0, 0, 3'b100, 2'd1);
        cycle("rst_add",  0, 0, 3'b011, 2'd2);
        cycle("rst_mid",  1, 0, 3'b000, 2'd0);
        cycle("rst_rel",  0, 0, 3'b000, 2'd0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
